// File: rtl/vedic_pkg.sv
// Shared definitions for the sequential Vedic multiplier controller.
//   state_e   : controller states (idle, multiply, done)
//   STEP_*    : step index of each partial product, in accumulation order
//   shift_amt : left shift applied to the partial product of a given step
package vedic_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StMul  = 2'd1,
      StDone = 2'd2
   } state_e;

   localparam logic [1:0] STEP_LL = 2'd0;  // a_lo * b_lo
   localparam logic [1:0] STEP_HL = 2'd1;  // a_hi * b_lo
   localparam logic [1:0] STEP_LH = 2'd2;  // a_lo * b_hi
   localparam logic [1:0] STEP_HH = 2'd3;  // a_hi * b_hi

   function automatic int unsigned shift_amt(input logic [1:0] step, input int unsigned n);
      int unsigned sh;
      case (step)
         STEP_LL:          sh = 0;
         STEP_HL, STEP_LH: sh = n / 2;
         default:          sh = n;
      endcase
      return sh;
   endfunction

endpackage

// File: rtl/vedic_mul_seq_ctrl_if.sv
// Handshake bundle between operand source, controller and product consumer.
//   in_valid/in_ready/in_a/in_b : operand channel (source -> controller)
//   out_valid/out_ready/out_p   : product channel (controller -> consumer)
//   busy                        : controller is multiplying or holding a result
// Modports: master = source/consumer side, slave = controller side.
interface vedic_mul_seq_ctrl_if #(
   parameter int unsigned N = 8
);
   logic           in_valid;
   logic           in_ready;
   logic [N-1:0]   in_a;
   logic [N-1:0]   in_b;
   logic           out_valid;
   logic           out_ready;
   logic [2*N-1:0] out_p;
   logic           busy;

   modport master (
      output in_valid, in_a, in_b, out_ready,
      input  in_ready, out_valid, out_p, busy
   );

   modport slave (
      input  in_valid, in_a, in_b, out_ready,
      output in_ready, out_valid, out_p, busy
   );
endinterface

// File: rtl/vedic_mul_nbit.sv
// Purely combinational W x W unsigned Vedic (Urdhva-Tiryagbhyam) multiplier core.
//   a_i, b_i : W-bit operands
//   p_o      : 2W-bit product
// Each output column k is the vertical/crosswise sum of all a[i]&b[j] with i+j==k;
// the column sums are then weighted by 2^k and added.
module vedic_mul_nbit #(
   parameter int unsigned W = 4
) (
   input  logic [W-1:0]   a_i,
   input  logic [W-1:0]   b_i,
   output logic [2*W-1:0] p_o
);

   logic [2*W-1:0] col;

   always_comb begin
      p_o = '0;
      col = '0;
      for (int k = 0; k < 2 * int'(W) - 1; k++) begin
         col = '0;
         for (int i = 0; i < int'(W); i++) begin
            for (int j = 0; j < int'(W); j++) begin
               if (i + j == k) begin
                  col = col + {{(2*W-1){1'b0}}, a_i[i] & b_i[j]};
               end
            end
         end
         p_o = p_o + (col << k);
      end
   end

endmodule

// File: rtl/vedic_mul_seq_ctrl.sv
// Multi-cycle N x N unsigned multiplier controller sharing one (N/2)x(N/2) Vedic core.
// Four partial products are accumulated over four MUL cycles; the result is then
// presented in DONE until the consumer accepts it.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : operand/product handshake bundle (slave side), plus busy status
module vedic_mul_seq_ctrl
   import vedic_pkg::*;
#(
   parameter int unsigned N = 8
) (
   input logic                 clk,
   input logic                 rst,
   vedic_mul_seq_ctrl_if.slave bus
);

   localparam int unsigned H = N / 2;

   state_e         state_q, state_d;
   logic [1:0]     step_q, step_d;
   logic [N-1:0]   a_q, a_d;
   logic [N-1:0]   b_q, b_d;
   logic [2*N-1:0] acc_q, acc_d;
   logic [2*N-1:0] out_p_q, out_p_d;

   logic [H-1:0]   core_a, core_b;
   logic [N-1:0]   core_p;
   logic [2*N-1:0] pp_shifted;
   logic [2*N-1:0] acc_sum;

   // Step bit 0 selects the high half of a, bit 1 the high half of b.
   always_comb begin
      core_a = a_q[H-1:0];
      core_b = b_q[H-1:0];
      unique case (step_q)
         STEP_LL: begin core_a = a_q[H-1:0]; core_b = b_q[H-1:0]; end
         STEP_HL: begin core_a = a_q[N-1:H]; core_b = b_q[H-1:0]; end
         STEP_LH: begin core_a = a_q[H-1:0]; core_b = b_q[N-1:H]; end
         STEP_HH: begin core_a = a_q[N-1:H]; core_b = b_q[N-1:H]; end
      endcase
   end

   vedic_mul_nbit #(
      .W (H)
   ) u_core (
      .a_i (core_a),
      .b_i (core_b),
      .p_o (core_p)
   );

   assign pp_shifted = {{N{1'b0}}, core_p} << shift_amt(step_q, N);
   assign acc_sum    = acc_q + pp_shifted;

   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      out_p_d = out_p_q;
      unique case (state_q)
         StIdle: begin
            if (bus.in_valid) begin
               a_d     = bus.in_a;
               b_d     = bus.in_b;
               acc_d   = '0;
               step_d  = STEP_LL;
               state_d = StMul;
            end
         end
         StMul: begin
            acc_d = acc_sum;
            if (step_q == STEP_HH) begin
               // Published copy so out_p stays put while the accumulator is reused.
               out_p_d = acc_sum;
               step_d  = STEP_LL;
               state_d = StDone;
            end else begin
               step_d = step_q + 2'd1;
            end
         end
         StDone: begin
            if (bus.out_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         step_q  <= STEP_LL;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         out_p_q <= '0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         out_p_q <= out_p_d;
      end
   end

   assign bus.in_ready  = (state_q == StIdle);
   assign bus.out_valid = (state_q == StDone);
   assign bus.busy      = (state_q != StIdle);
   assign bus.out_p     = out_p_q;

endmodule

// File: tb/tb_vedic_mul_seq_ctrl.sv
module tb_vedic_mul_seq_ctrl;

   localparam int unsigned N = 8;

   logic clk;
   logic rst;
   int   tests;
   int   fails;
   logic [2*N-1:0] sb[$];

   vedic_mul_seq_ctrl_if #(.N(N)) bus_if ();

   vedic_mul_seq_ctrl #(
      .N (N)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference accumulator after partial product k (0..3), in the order LL, HL, LH, HH.
   function automatic logic [15:0] model_acc(input logic [7:0] a, input logic [7:0] b,
                                             input int k);
      logic [15:0] al, ah, bl, bh, s;
      al = {12'd0, a[3:0]};
      ah = {12'd0, a[7:4]};
      bl = {12'd0, b[3:0]};
      bh = {12'd0, b[7:4]};
      s = al * bl;
      if (k >= 1) s = s + ((ah * bl) << 4);
      if (k >= 2) s = s + ((al * bh) << 4);
      if (k >= 3) s = s + ((ah * bh) << 8);
      return s;
   endfunction

   // One transaction: accept, wait for the product, optional backpressure / garbage.
   task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input int ready_low, input bit inter, input bit garb);
      int n;
      logic [15:0] exp;
      logic [15:0] held;
      sb.push_back(16'(a) * 16'(b));
      bus_if.in_a      = a;
      bus_if.in_b      = b;
      bus_if.in_valid  = 1'b1;
      bus_if.out_ready = (ready_low == 0);
      chk({tag, "_in_ready_idle"}, 32'(bus_if.in_ready), 32'd1);
      tick();
      if (garb) begin
         bus_if.in_a = ~a;
         bus_if.in_b = b ^ 8'h5A;
      end else begin
         bus_if.in_valid = 1'b0;
      end
      n = 0;
      while (bus_if.out_valid !== 1'b1 && n < 20) begin
         if (garb) chk({tag, "_in_ready_mul"}, 32'(bus_if.in_ready), 32'd0);
         chk({tag, "_busy"}, 32'(bus_if.busy), 32'd1);
         tick();
         n++;
         if (inter && n <= 4)
            chk($sformatf("%s_acc%0d", tag, n - 1), 32'(dut.acc_q), 32'(model_acc(a, b, n - 1)));
      end
      chk({tag, "_latency"}, 32'(n), 32'd4);
      if (sb.size() == 0) begin
         chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
         exp = '0;
      end else begin
         exp = sb.pop_front();
      end
      chk({tag, "_out_p"}, 32'(bus_if.out_p), 32'(exp));
      held = bus_if.out_p;
      for (int i = 0; i < ready_low; i++) begin
         chk({tag, "_hold_valid"}, 32'(bus_if.out_valid), 32'd1);
         chk({tag, "_hold_p"}, 32'(bus_if.out_p), 32'(held));
         if (garb) chk({tag, "_in_ready_done"}, 32'(bus_if.in_ready), 32'd0);
         tick();
      end
      bus_if.out_ready = 1'b1;
      bus_if.in_valid  = 1'b0;
      chk({tag, "_valid_before_ack"}, 32'(bus_if.out_valid), 32'd1);
      tick();
      chk({tag, "_valid_after_ack"}, 32'(bus_if.out_valid), 32'd0);
      chk({tag, "_in_ready_back"}, 32'(bus_if.in_ready), 32'd1);
      chk({tag, "_p_kept"}, 32'(bus_if.out_p), 32'(exp));
   endtask

   initial begin
      logic [7:0] pa[3];
      logic [7:0] pb[3];
      logic [15:0] exp;
      int idx, got, cyc, last;
      bit acc_now;

      tests = 0;
      fails = 0;
      bus_if.in_valid  = 1'b0;
      bus_if.in_a      = '0;
      bus_if.in_b      = '0;
      bus_if.out_ready = 1'b1;
      rst = 1'b1;
      #12;
      chk("rst_in_ready", 32'(bus_if.in_ready), 32'd1);
      chk("rst_out_valid", 32'(bus_if.out_valid), 32'd0);
      chk("rst_busy", 32'(bus_if.busy), 32'd0);
      chk("rst_out_p", 32'(bus_if.out_p), 32'd0);
      rst = 1'b0;
      tick();

      run_op("t12x34", 8'h12, 8'h34, 0, 1'b0, 1'b0);
      run_op("tFFxFF", 8'hFF, 8'hFF, 0, 1'b1, 1'b0);
      run_op("t00xA5", 8'h00, 8'hA5, 0, 1'b0, 1'b0);
      run_op("t0Fx10", 8'h0F, 8'h10, 3, 1'b0, 1'b0);
      run_op("tgarb", 8'h9C, 8'h37, 2, 1'b1, 1'b1);

      // Reset during step 2 of 0xAB x 0xCD discards the operation.
      sb.push_back(16'h00AB * 16'h00CD);
      bus_if.in_a     = 8'hAB;
      bus_if.in_b     = 8'hCD;
      bus_if.in_valid = 1'b1;
      tick();
      bus_if.in_valid = 1'b0;
      tick();
      tick();
      chk("rst_mid_step", 32'(dut.step_q), 32'd2);
      rst = 1'b1;
      sb.delete();
      #2;
      chk("rst_mid_out_valid", 32'(bus_if.out_valid), 32'd0);
      chk("rst_mid_in_ready", 32'(bus_if.in_ready), 32'd1);
      chk("rst_mid_out_p", 32'(bus_if.out_p), 32'd0);
      chk("rst_mid_busy", 32'(bus_if.busy), 32'd0);
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("rst_no_pulse", 32'(bus_if.out_valid), 32'd0);
      end
      run_op("t03x05", 8'h03, 8'h05, 0, 1'b0, 1'b0);

      // Back-to-back: in_valid held high across three pairs.
      pa[0] = 8'h21; pb[0] = 8'h43;
      pa[1] = 8'hE7; pb[1] = 8'h99;
      pa[2] = 8'h80; pb[2] = 8'hFE;
      idx = 0; got = 0; cyc = 0; last = 0;
      bus_if.out_ready = 1'b1;
      bus_if.in_a      = pa[0];
      bus_if.in_b      = pb[0];
      bus_if.in_valid  = 1'b1;
      sb.push_back(16'(pa[0]) * 16'(pb[0]));
      while (got < 3 && cyc < 60) begin
         if (bus_if.out_valid === 1'b1) begin
            exp = (sb.size() > 0) ? sb.pop_front() : 16'hxxxx;
            chk($sformatf("b2b_p%0d", got), 32'(bus_if.out_p), 32'(exp));
            if (got > 0) chk($sformatf("b2b_gap%0d", got), 32'(cyc - last), 32'd6);
            last = cyc;
            got++;
         end
         if (bus_if.in_ready === 1'b1 && bus_if.out_valid === 1'b1)
            chk("b2b_exclusive", 32'd1, 32'd0);
         acc_now = (bus_if.in_ready === 1'b1) && bus_if.in_valid;
         tick();
         cyc++;
         if (acc_now) begin
            idx++;
            if (idx < 3) begin
               bus_if.in_a = pa[idx];
               bus_if.in_b = pb[idx];
               sb.push_back(16'(pa[idx]) * 16'(pb[idx]));
            end else begin
               bus_if.in_valid = 1'b0;
            end
         end
      end
      chk("b2b_count", 32'(got), 32'd3);
      chk("b2b_accepts", 32'(idx), 32'd3);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
